multicycle_processor: RTL

// - Multi-cycle MIPS-subset core: the successor to the single-cycle processor top.
// - One shared external memory port with a req/ready handshake, so instruction and data memories may insert wait states.
// - Explicit FSM: FETCH, DECODE, EXEC, MEM, WB and HALT.
// - Halts on an illegal opcode or a misaligned access and reports the cause.

---
 rtl/multicycle_processor.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core sharing one req/ready memory port for fetch and data.
// Each instruction walks FETCH/DECODE/EXEC[/MEM][/WB]; illegal or misaligned work parks the core in HALT.
module multicycle_processor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ADDR_W      = 32,
  parameter bit          HALT_ON_MIS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       PC,
  output logic [31:0]       Current_Instruction,
  output logic [31:0]       ALU_Result,
  output logic              retire,
  output logic              halted,
  output logic [1:0]        halt_cause
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  logic [2:0]        r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_alu;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_imm;
  logic [31:0]       r_mdr;
  logic [31:0]       r_regs [32];
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_halted;
  logic [1:0]        r_halt_cause;

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [4:0]        w_shamt;
  logic [31:0]       w_imm_sext;
  logic [31:0]       w_rs_val;
  logic [31:0]       w_rt_val;
  logic              w_legal;
  logic              w_is_ctrl;
  logic              w_is_mem;
  logic              w_is_sw;
  logic [31:0]       w_alu;
  logic [31:0]       w_pc_next;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_data_addr;
  logic [4:0]        w_wb_dst;
  logic [31:0]       w_wb_val;
  logic              w_retire;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_shamt    = r_ir[10:6];
  assign w_funct    = r_ir[5:0];
  assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  // Instruction classification from the latched IR
  always_comb begin
    w_legal   = 1'b0;
    w_is_ctrl = 1'b0;
    w_is_mem  = 1'b0;
    w_is_sw   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: w_legal = 1'b1;
          FN_JR: begin
            w_legal   = 1'b1;
            w_is_ctrl = 1'b1;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_ADDI: w_legal = 1'b1;
      OP_LW: begin
        w_legal  = 1'b1;
        w_is_mem = 1'b1;
      end
      OP_SW: begin
        w_legal  = 1'b1;
        w_is_mem = 1'b1;
        w_is_sw  = 1'b1;
      end
      OP_BEQ, OP_J, OP_JAL: begin
        w_legal   = 1'b1;
        w_is_ctrl = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // ALU on the operands latched in DECODE
  always_comb begin
    w_alu = 32'd0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  w_alu = r_a + r_b;
          FN_SUB:  w_alu = r_a - r_b;
          FN_AND:  w_alu = r_a & r_b;
          FN_OR:   w_alu = r_a | r_b;
          FN_SLT:  w_alu = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
          FN_SLL:  w_alu = r_b << w_shamt;
          default: w_alu = 32'd0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: w_alu = r_a + r_imm;
      default: w_alu = 32'd0;
    endcase
  end

  // Control-flow target; r_pc already points past the instruction here
  always_comb begin
    w_pc_next = r_pc;
    case (w_op)
      OP_BEQ: begin
        if (r_a == r_b) w_pc_next = r_pc + {r_imm[29:0], 2'b00};
        else            w_pc_next = r_pc;
      end
      OP_J, OP_JAL: w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      OP_RTYPE:     w_pc_next = r_a;
      default:      w_pc_next = r_pc;
    endcase
  end

  assign w_misaligned = (w_alu[1:0] != 2'b00);
  assign w_data_addr  = HALT_ON_MIS ? w_alu[ADDR_W-1:0] : {w_alu[ADDR_W-1:2], 2'b00};

  // Write-back destination and source
  always_comb begin
    w_wb_dst = 5'd0;
    w_wb_val = r_alu;
    case (w_op)
      OP_RTYPE: w_wb_dst = w_rd;
      OP_ADDI:  w_wb_dst = w_rt;
      OP_LW: begin
        w_wb_dst = w_rt;
        w_wb_val = r_mdr;
      end
      default: w_wb_dst = 5'd0;
    endcase
  end

  // Retire marks the final cycle of each instruction, so a store retires on its ready cycle
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_EXEC:  w_retire = w_is_ctrl;
      S_MEM:   w_retire = w_is_sw & mem_ready;
      S_WB:    w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  // Main FSM, architectural state and memory port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= 32'd0;
      r_alu        <= 32'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_imm        <= 32'd0;
      r_mdr        <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_halted     <= 1'b0;
      r_halt_cause <= CAUSE_NONE;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Only the first fetch after reset arrives here without a request already raised
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc[ADDR_W-1:0];
          end else if (mem_ready) begin
            r_ir      <= mem_rdata;
            r_pc      <= r_pc + 32'd4;
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DECODE: begin
          r_a   <= w_rs_val;
          r_b   <= w_rt_val;
          r_imm <= w_imm_sext;
          if (!w_legal) begin
            r_halted     <= 1'b1;
            r_halt_cause <= CAUSE_ILLEGAL;
            r_state      <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_is_mem) begin
            if (HALT_ON_MIS && w_misaligned) begin
              r_halted     <= 1'b1;
              r_halt_cause <= CAUSE_MISALIGN;
              r_state      <= S_HALT;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_sw;
              r_mem_addr  <= w_data_addr;
              r_mem_wdata <= r_b;
              r_state     <= S_MEM;
            end
          end else if (w_is_ctrl) begin
            if (w_op == OP_JAL) r_regs[31] <= r_pc;
            r_pc       <= w_pc_next;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_pc_next[ADDR_W-1:0];
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_mem_we <= 1'b0;
            if (w_is_sw) begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_pc[ADDR_W-1:0];
              r_state    <= S_FETCH;
            end else begin
              r_mdr     <= mem_rdata;
              r_mem_req <= 1'b0;
              r_state   <= S_WB;
            end
          end else begin
            r_state <= S_MEM;
          end
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) r_regs[w_wb_dst] <= w_wb_val;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc[ADDR_W-1:0];
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= S_HALT;
        end
        default: begin
          r_mem_req    <= 1'b0;
          r_mem_we     <= 1'b0;
          r_halted     <= 1'b1;
          r_halt_cause <= CAUSE_ILLEGAL;
          r_state      <= S_HALT;
        end
      endcase
    end
  end

  assign mem_req             = r_mem_req;
  assign mem_we              = r_mem_we;
  assign mem_addr            = r_mem_addr;
  assign mem_wdata           = r_mem_wdata;
  assign PC                  = r_pc;
  assign Current_Instruction = r_ir;
  assign ALU_Result          = r_alu;
  assign retire              = w_retire & ~reset;
  assign halted              = r_halted;
  assign halt_cause          = r_halt_cause;

endmodule
